graycode_counter_param: RTL
===========================

Name: graycode_counter_param

Overview:
Parametrised up/down Gray-code counter. It is the generalised successor to the fixed 3-bit Gray counter.
- Adds configurable width, enable, synchronous parallel load, and wrap or saturate end behaviour.
- Adds a terminal-count flag and a one-cycle wrap pulse.
- Exposes both Gray and binary views of the count. Used as a sequencer/pointer source for FIFO and state-sequencing logic.

Parameters:
WIDTH, 3, counter width in bits (legal 2..16)
SATURATE, 0, 0 = wrap at end of range; 1 = hold at end of range
INIT_VAL, 0, binary value loaded on reset (must be < 2**WIDTH)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  count enable; one step per cycle while high
dir  input  1  direction: 0 = up, 1 = down
load  input  1  synchronous load strobe
load_val  input  WIDTH  binary value to load
gray_out  output  WIDTH  current count, Gray-coded
bin_out  output  WIDTH  current count, binary
tc  output  1  terminal count: count at end of range for current dir
wrap  output  1  registered one-cycle pulse: previous step wrapped
ovf_cnt  output  8  wrap-event counter (present only with GCC_OVF_CNT_EN)

Behaviour:
- State is a WIDTH-bit binary register `cnt` plus a registered `wrap` flag.
- gray_out = cnt ^ (cnt >> 1), combinational from the register. bin_out = cnt. Both have zero added latency.
- Reset (rst=1 at posedge): cnt <= INIT_VAL, wrap <= 0, ovf_cnt <= 0. Reset overrides load and en, including mid-count.
- Priority per edge: rst > load > en.
- Load (load=1, rst=0): cnt <= load_val; wrap <= 0. en and dir are ignored that cycle.
- Count (en=1, load=0, rst=0):
  - dir=0: cnt <= cnt+1.
  - dir=1: cnt <= cnt-1.
- End-of-range, up (cnt = 2**WIDTH-1, dir=0):
  - SATURATE=0: cnt <= 0, wrap <= 1.
  - SATURATE=1: cnt holds, wrap <= 0.
- End-of-range, down (cnt = 0, dir=1):
  - SATURATE=0: cnt <= 2**WIDTH-1, wrap <= 1.
  - SATURATE=1: cnt holds, wrap <= 0.
- Idle (en=0, load=0): cnt holds; wrap <= 0.
- wrap is high for exactly one cycle after each wrap step.
- tc is combinational: (dir=0 && cnt all ones) || (dir=1 && cnt = 0). It is independent of en.
- dir may change on any cycle; the next step uses the new dir. No settling cycle is required.
- Every counting step changes exactly one bit of gray_out, including across the wrap boundary.
- Load and reset may change multiple Gray bits.
- Arithmetic is modulo 2**WIDTH. No carry-out beyond the wrap flag.

Optional Feature:
Macro GCC_OVF_CNT_EN.
- Defined: 8-bit port ovf_cnt exists.
  - Increments by 1 on every cycle in which wrap is set (i.e. same edge the wrap step occurs).
  - Wraps 255->0.
  - Cleared by rst only; load does not clear it.
- Undefined: port and register absent. All other behaviour identical.

Test Plan:
- Up-count: WIDTH=3, rst 1 cycle, en=1, dir=0 for 9 cycles -> gray_out 000,001,011,010,110,111,101,100,000. wrap=1 in the cycle showing 000 after 100. tc=1 while gray_out=100.
- Down-count: after reset, en=1, dir=1 -> bin_out 0,7,6,5. gray_out 000,100,101,111. wrap=1 in the cycle after 0->7.
- Saturate: SATURATE=1, WIDTH=4, load load_val=14, en=1, dir=0 for 4 cycles -> bin_out 14,15,15,15. wrap never set. tc=1 from bin_out=15. Then dir=1 -> bin_out 14.
- Load/enable/reset priority:
  - load=1, load_val=5, en=1 -> bin_out=5 next cycle (no increment).
  - rst=1 with load=1 -> bin_out=INIT_VAL.
  - rst asserted mid-count at bin_out=3 -> 0 next edge.
  - en=0 holds value.
- Single-bit-change check: WIDTH=8, free-run 600 cycles with dir toggled every 37 cycles -> popcount(gray_out ^ previous gray_out)=1 on every enabled step.
- GCC_OVF_CNT_EN defined: WIDTH=2 up-count 20 cycles -> ovf_cnt=5. load does not clear it; rst clears it to 0.

Source files
------------

// File: rtl/graycode_counter_param.sv
// Parametrised up/down Gray-code counter with load, enable, wrap or saturate end behaviour.
// Optional 8-bit wrap-event counter on port ovf_cnt when GCC_OVF_CNT_EN is defined.
module graycode_counter_param #(
    parameter int unsigned WIDTH    = 3,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned INIT_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             wrap
`ifdef GCC_OVF_CNT_EN
    ,
    output logic [7:0]       ovf_cnt
`endif
);

    localparam logic [WIDTH-1:0] MaxVal  = '1;
    localparam logic [WIDTH-1:0] InitVal = WIDTH'(INIT_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             at_end;

    // End of range depends on the direction currently requested, not on en.
    assign at_end = dir ? (cnt_q == '0) : (cnt_q == MaxVal);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (at_end && SATURATE) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d  = dir ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
                wrap_d = at_end;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= InitVal;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef GCC_OVF_CNT_EN
    logic [7:0] ovf_q, ovf_d;

    assign ovf_d = ovf_q + {7'd0, wrap_d};

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_cnt = ovf_q;
`endif

    assign bin_out  = cnt_q;
    assign gray_out = cnt_q ^ (cnt_q >> 1);
    assign tc       = at_end;
    assign wrap     = wrap_q;

endmodule
